// File: rtl/uart_tx_fifo_param.sv
// Single-clock UART transmitter with an integrated circular FIFO and an internal
// bit-period counter; frames are start, DATA_BITS LSB first, optional parity, stop.
module uart_tx_fifo_param #(
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tx_en,
    input  logic                          tx_byte,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx,
    output logic                          tx_full,
    output logic                          tx_empty,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic                          txing
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST  = 4'(STOP_BITS - 1);
    localparam logic [LW-1:0] DEPTH_FULL = LW'(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [LW-1:0]        wr_ptr_r, rd_ptr_r, wr_nxt_s, rd_nxt_s, level_nxt_s;
    logic [LW-1:0]        level_r;
    logic                 full_r, empty_r;
    logic [2:0]           state_r, state_nxt_s;
    logic [CW-1:0]        baud_r, baud_nxt_s;
    logic [3:0]           bit_r, bit_nxt_s;
    logic [DATA_BITS-1:0] shift_r, shift_nxt_s, head_s;
    logic                 par_r, par_nxt_s;
    logic                 tx_r, tx_nxt_s, txing_r;
    logic                 push_s, pop_s, baud_done_s, frame_ok_s;

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        logic p;
        p = ^d;
        if (PARITY == 1) begin
            return ~p;
        end else begin
            return p;
        end
    endfunction

    assign push_s      = tx_byte & ~full_r;
    assign head_s      = mem_r[rd_ptr_r[AW-1:0]];
    assign baud_done_s = (baud_r == BAUD_LAST);
    assign frame_ok_s  = tx_en & ~empty_r;

    // Extra pointer bit keeps full (difference = depth) apart from empty (difference = 0).
    assign wr_nxt_s    = push_s ? (wr_ptr_r + LW'(1)) : wr_ptr_r;
    assign rd_nxt_s    = pop_s  ? (rd_ptr_r + LW'(1)) : rd_ptr_r;
    assign level_nxt_s = wr_nxt_s - rd_nxt_s;

    // FIFO storage write port; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= tx_data;
        end
    end

    // FIFO pointers and registered occupancy flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            wr_ptr_r <= wr_nxt_s;
            rd_ptr_r <= rd_nxt_s;
            level_r  <= level_nxt_s;
            full_r   <= (level_nxt_s == DEPTH_FULL);
            empty_r  <= (level_nxt_s == '0);
        end
    end

    // Frame sequencer: tx_nxt_s is the line level belonging to the current state.
    always_comb begin
        state_nxt_s = state_r;
        baud_nxt_s  = baud_r;
        bit_nxt_s   = bit_r;
        shift_nxt_s = shift_r;
        par_nxt_s   = par_r;
        tx_nxt_s    = 1'b1;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                tx_nxt_s   = 1'b1;
                baud_nxt_s = '0;
                bit_nxt_s  = 4'd0;
                if (frame_ok_s) begin
                    pop_s       = 1'b1;
                    shift_nxt_s = head_s;
                    par_nxt_s   = parity_bit(head_s);
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                tx_nxt_s = 1'b0;
                if (baud_done_s) begin
                    baud_nxt_s  = '0;
                    bit_nxt_s   = 4'd0;
                    state_nxt_s = ST_DATA;
                end else begin
                    baud_nxt_s = baud_r + CW'(1);
                end
            end
            ST_DATA: begin
                tx_nxt_s = shift_r[0];
                if (baud_done_s) begin
                    baud_nxt_s  = '0;
                    shift_nxt_s = {1'b0, shift_r[DATA_BITS-1:1]};
                    if (bit_r == DATA_LAST) begin
                        bit_nxt_s = 4'd0;
                        if (PARITY != 0) begin
                            state_nxt_s = ST_PARITY;
                        end else begin
                            state_nxt_s = ST_STOP;
                        end
                    end else begin
                        bit_nxt_s = bit_r + 4'd1;
                    end
                end else begin
                    baud_nxt_s = baud_r + CW'(1);
                end
            end
            ST_PARITY: begin
                tx_nxt_s = par_r;
                if (baud_done_s) begin
                    baud_nxt_s  = '0;
                    bit_nxt_s   = 4'd0;
                    state_nxt_s = ST_STOP;
                end else begin
                    baud_nxt_s = baud_r + CW'(1);
                end
            end
            ST_STOP: begin
                tx_nxt_s = 1'b1;
                if (baud_done_s) begin
                    baud_nxt_s = '0;
                    if (bit_r == STOP_LAST) begin
                        bit_nxt_s = 4'd0;
                        // Chain straight into the next start bit to avoid an idle gap.
                        if (frame_ok_s) begin
                            pop_s       = 1'b1;
                            shift_nxt_s = head_s;
                            par_nxt_s   = parity_bit(head_s);
                            state_nxt_s = ST_START;
                        end else begin
                            state_nxt_s = ST_IDLE;
                        end
                    end else begin
                        bit_nxt_s = bit_r + 4'd1;
                    end
                end else begin
                    baud_nxt_s = baud_r + CW'(1);
                end
            end
            default: begin
                tx_nxt_s    = 1'b1;
                baud_nxt_s  = '0;
                bit_nxt_s   = 4'd0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and registered line outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            baud_r  <= '0;
            bit_r   <= 4'd0;
            shift_r <= '0;
            par_r   <= 1'b0;
            tx_r    <= 1'b1;
            txing_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            baud_r  <= baud_nxt_s;
            bit_r   <= bit_nxt_s;
            shift_r <= shift_nxt_s;
            par_r   <= par_nxt_s;
            tx_r    <= tx_nxt_s;
            txing_r <= (state_nxt_s != ST_IDLE);
        end
    end

    assign tx       = tx_r;
    assign txing    = txing_r;
    assign tx_full  = full_r;
    assign tx_empty = empty_r;
    assign tx_level = level_r;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Directed/random bench for uart_tx_fifo_param: two instances (8E1 and 7O2) checked
// against a queue-based reference that builds each expected frame bit by bit.
module tb_uart_tx_fifo_param;

    localparam int DEP   = 4;
    localparam int CPB_A = 4;
    localparam int DB_A  = 8;
    localparam int PAR_A = 2;
    localparam int SB_A  = 1;
    localparam int CPB_B = 3;
    localparam int DB_B  = 7;
    localparam int PAR_B = 1;
    localparam int SB_B  = 2;

    logic       clk = 1'b0;
    logic       reset_a, en_a, byte_a, tx_a, full_a, empty_a, txing_a;
    logic [7:0] data_a;
    logic [2:0] level_a;
    logic       reset_b, en_b, byte_b, tx_b, full_b, empty_b, txing_b;
    logic [6:0] data_b;
    logic [2:0] level_b;

    int errors = 0;
    int checks = 0;
    logic [8:0] q_a[$];
    logic [8:0] q_b[$];

    always #5 clk = ~clk;

    uart_tx_fifo_param #(.DATA_BITS(DB_A), .PARITY(PAR_A), .STOP_BITS(SB_A),
                         .CLKS_PER_BIT(CPB_A), .FIFO_DEPTH(DEP)) dut_a (
        .clk(clk), .reset(reset_a), .tx_en(en_a), .tx_byte(byte_a), .tx_data(data_a),
        .tx(tx_a), .tx_full(full_a), .tx_empty(empty_a), .tx_level(level_a), .txing(txing_a));

    uart_tx_fifo_param #(.DATA_BITS(DB_B), .PARITY(PAR_B), .STOP_BITS(SB_B),
                         .CLKS_PER_BIT(CPB_B), .FIFO_DEPTH(DEP)) dut_b (
        .clk(clk), .reset(reset_b), .tx_en(en_b), .tx_byte(byte_b), .tx_data(data_b),
        .tx(tx_b), .tx_full(full_b), .tx_empty(empty_b), .tx_level(level_b), .txing(txing_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic get_tx(input bit sel);
        return sel ? tx_b : tx_a;
    endfunction

    function automatic logic get_txing(input bit sel);
        return sel ? txing_b : txing_a;
    endfunction

    // One-cycle write strobe; the model keeps the byte only if it has room.
    task automatic push(input bit sel, input logic [8:0] d);
        if (sel) begin
            byte_b = 1'b1;
            data_b = d[6:0];
            if (q_b.size() < DEP) q_b.push_back({2'b00, d[6:0]});
        end else begin
            byte_a = 1'b1;
            data_a = d[7:0];
            if (q_a.size() < DEP) q_a.push_back({1'b0, d[7:0]});
        end
        tick();
        byte_a = 1'b0;
        byte_b = 1'b0;
    endtask

    // Wait (bounded) for the start bit, then check every cycle of the expected frame.
    task automatic expect_frame(input bit sel, input string tag, input int maxwait,
                                input int drop_at, output int txing_cnt);
        logic [8:0] d;
        int bits[16];
        int n, nb, par, sb, cpb, ones, w, bad, cyc;
        d = 9'h000;
        if (sel) begin
            if (q_b.size() > 0) d = q_b.pop_front();
            nb = DB_B; par = PAR_B; sb = SB_B; cpb = CPB_B;
        end else begin
            if (q_a.size() > 0) d = q_a.pop_front();
            nb = DB_A; par = PAR_A; sb = SB_A; cpb = CPB_A;
        end
        n = 0;
        bits[n++] = 0;
        ones = 0;
        for (int i = 0; i < nb; i++) begin
            bits[n++] = int'(d[i]);
            ones += int'(d[i]);
        end
        if (par == 2) bits[n++] = ones % 2;
        else if (par == 1) bits[n++] = 1 - (ones % 2);
        for (int s = 0; s < sb; s++) bits[n++] = 1;
        w = 0;
        while (get_tx(sel) !== 1'b0 && w < maxwait) begin
            tick();
            w++;
        end
        chk($sformatf("%s start_seen", tag), get_tx(sel), 0);
        txing_cnt = 0;
        cyc = 0;
        for (int b = 0; b < n; b++) begin
            bad = 0;
            for (int c = 0; c < cpb; c++) begin
                if (cyc == drop_at) begin
                    if (sel) en_b = 1'b0;
                    else en_a = 1'b0;
                end
                if (get_tx(sel) !== bits[b][0]) bad++;
                if (get_txing(sel) === 1'b1) txing_cnt++;
                tick();
                cyc++;
            end
            chk($sformatf("%s bit%0d wrong_cycles", tag, b), bad, 0);
        end
    endtask

    initial begin
        int cnt, hi, busy, w;
        logic [8:0] r;
        reset_a = 1'b1; reset_b = 1'b1;
        en_a = 1'b0; en_b = 1'b0; byte_a = 1'b0; byte_b = 1'b0;
        data_a = 8'h00; data_b = 7'h00;
        tick(); tick();
        reset_a = 1'b0; reset_b = 1'b0;
        chk("rst tx_a", tx_a, 1);
        chk("rst txing_a", txing_a, 0);
        chk("rst empty_a", empty_a, 1);
        chk("rst full_a", full_a, 0);
        chk("rst level_a", level_a, 0);
        chk("rst tx_b", tx_b, 1);
        chk("rst empty_b", empty_b, 1);

        // 0xA5, even parity: latency, frame bits and 44-cycle busy window
        en_a = 1'b1;
        push(1'b0, 9'h0A5);
        chk("t1 empty_after_write", empty_a, 0);
        chk("t1 level_after_write", level_a, 1);
        chk("t1 txing_before_pop", txing_a, 0);
        tick();
        chk("t1 level_after_pop", level_a, 0);
        chk("t1 txing_after_pop", txing_a, 1);
        chk("t1 tx_still_high", tx_a, 1);
        tick();
        expect_frame(1'b0, "t1", 0, -1, cnt);
        chk("t1 txing_len", cnt + 1, 44);
        chk("t1 txing_after", txing_a, 0);

        // fill past full with tx_en low, then drain back to back
        en_a = 1'b0;
        for (int k = 1; k <= 5; k++) push(1'b0, 9'(k));
        chk("t3 full", full_a, 1);
        chk("t3 level", level_a, 4);
        en_a = 1'b1;
        expect_frame(1'b0, "t3 f1", 5, -1, cnt);
        for (int k = 2; k <= 4; k++) expect_frame(1'b0, $sformatf("t3 f%0d b2b", k), 0, -1, cnt);
        chk("t3 empty", empty_a, 1);
        chk("t3 level_end", level_a, 0);
        hi = 0;
        repeat (40) begin
            if (tx_a === 1'b1 && txing_a === 1'b0) hi++;
            tick();
        end
        chk("t3 dropped_byte_not_sent", hi, 40);

        // push on the same edge as a pop at level 2
        en_a = 1'b0;
        for (int k = 0; k < 2; k++) begin
            r = {1'b0, 8'($urandom_range(0, 255))};
            push(1'b0, r);
        end
        chk("t4 level_before", level_a, 2);
        r = {1'b0, 8'($urandom_range(0, 255))};
        en_a = 1'b1;
        byte_a = 1'b1;
        data_a = r[7:0];
        q_a.push_back(r);
        tick();
        byte_a = 1'b0;
        chk("t4 level_push_pop", level_a, 2);
        chk("t4 txing", txing_a, 1);
        expect_frame(1'b0, "t4 f1", 3, -1, cnt);
        expect_frame(1'b0, "t4 f2", 0, -1, cnt);
        expect_frame(1'b0, "t4 f3", 0, -1, cnt);

        // tx_en dropped in data bit 3 of 0x3C with 0x55 queued
        en_a = 1'b0;
        push(1'b0, 9'h03C);
        push(1'b0, 9'h055);
        en_a = 1'b1;
        expect_frame(1'b0, "t5 3c", 5, 4 * CPB_A + 1, cnt);
        hi = 0;
        repeat (60) begin
            if (tx_a === 1'b1 && txing_a === 1'b0) hi++;
            tick();
        end
        chk("t5 held_idle", hi, 60);
        chk("t5 level", level_a, 1);
        en_a = 1'b1;
        expect_frame(1'b0, "t5 55", 5, -1, cnt);

        // 7 data bits, odd parity, two stop bits
        en_b = 1'b1;
        push(1'b1, 9'h007);
        expect_frame(1'b1, "t2", 5, -1, cnt);
        chk("t2 txing_len", cnt + 1, (1 + DB_B + 1 + SB_B) * CPB_B);
        en_b = 1'b0;
        for (int k = 0; k < 3; k++) push(1'b1, {2'b00, 7'($urandom_range(0, 127))});
        en_b = 1'b1;
        expect_frame(1'b1, "t2 r1", 5, -1, cnt);
        expect_frame(1'b1, "t2 r2", 0, -1, cnt);
        expect_frame(1'b1, "t2 r3", 0, -1, cnt);

        // reset mid-data with three bytes still queued
        en_b = 1'b0;
        for (int k = 0; k < 4; k++) push(1'b1, {2'b00, 7'($urandom_range(0, 127))});
        chk("t6 level_before", level_b, 4);
        en_b = 1'b1;
        w = 0;
        while (tx_b !== 1'b0 && w < 10) begin
            tick();
            w++;
        end
        chk("t6 start_seen", tx_b, 0);
        repeat (CPB_B * 3) tick();
        chk("t6 level_mid", level_b, 3);
        reset_b = 1'b1;
        tick();
        reset_b = 1'b0;
        q_b.delete();
        chk("t6 tx", tx_b, 1);
        chk("t6 txing", txing_b, 0);
        chk("t6 empty", empty_b, 1);
        chk("t6 level", level_b, 0);
        chk("t6 full", full_b, 0);
        hi = 0;
        busy = 0;
        repeat (60) begin
            if (tx_b === 1'b1) hi++;
            if (txing_b !== 1'b0) busy++;
            tick();
        end
        chk("t6 line_idle", hi, 60);
        chk("t6 no_frames", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
